// File: rtl/hevc_ms_pkg.sv
// Shared constants and the tagged-token layout for the multi-stream HEVC interpolation path.
// No logic, no latency; the tag-width helper keeps the tag at least one bit wide even for FLUX < 2.
package hevc_ms_pkg;

    localparam int DATA_WIDTH  = 8;
    localparam int ALPHA_WIDTH = 7;
    localparam int SIZE_WIDTH  = 7;

    function automatic int tag_w(input int flux);
        return (flux <= 2) ? 1 : $clog2(flux);
    endfunction

    localparam int TOK_TAG_W = tag_w(2);

    // Token layout for the default two-stream build: tag sits above the sample.
    typedef struct packed {
        logic [TOK_TAG_W-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } ms_token_t;

endpackage

// File: rtl/hevc_ms_stream_fifo.sv
// Single-stream synchronous first-word-fall-through FIFO; head is valid whenever empty is low.
// Latency 1 cycle write-to-visible; writes are dropped while full and reads are ignored while empty.
module hevc_ms_stream_fifo #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic                  wr_en;
    logic                  rd_en;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign wr_en = wr & ~full;
    assign rd_en = rd & ~empty;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (wr_en && !rd_en) begin
            count_d = count_q + 1'b1;
        end else if (rd_en && !wr_en) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= ptr_next(wr_ptr_q);
            end
            if (rd_en) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/hevc_ms_out_demux.sv
// Routes tagged tokens into per-stream FWFT FIFOs so each consumer drains its stream independently.
// Latency 1 cycle write-to-head; per-stream full back to the producer, dropped writes set sticky err.
module hevc_ms_out_demux
    import hevc_ms_pkg::tag_w;
#(
    parameter  int DEPTH      = 16,
    parameter  int FLUX       = 2,
    parameter  int DATA_WIDTH = 8,
    localparam int TAG_WIDTH  = tag_w(FLUX)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_WIDTH+TAG_WIDTH-1:0] in_din,
    input  logic                            in_write,
    output logic [FLUX-1:0]                 in_full,
    output logic [FLUX*DATA_WIDTH-1:0]      out_dout,
    output logic [FLUX-1:0]                 out_empty,
    input  logic [FLUX-1:0]                 out_read,
    output logic                            err
);

    localparam logic [TAG_WIDTH:0] FLUX_L = (TAG_WIDTH + 1)'(FLUX);

    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
    logic                  tag_ok;
    logic [FLUX-1:0]       sel;
    logic                  bad_wr;
    logic                  err_q;

    assign tag    = in_din[DATA_WIDTH+TAG_WIDTH-1 -: TAG_WIDTH];
    assign data   = in_din[DATA_WIDTH-1:0];
    assign tag_ok = ({1'b0, tag} < FLUX_L);

    for (genvar i = 0; i < FLUX; i++) begin : g_stream
        assign sel[i] = tag_ok && (tag == TAG_WIDTH'(i));

        hevc_ms_stream_fifo #(
            .DEPTH      (DEPTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .wr    (in_write & sel[i]),
            .din   (data),
            .full  (in_full[i]),
            .rd    (out_read[i]),
            .dout  (out_dout[i*DATA_WIDTH +: DATA_WIDTH]),
            .empty (out_empty[i])
        );
    end

    // Full is the registered pre-edge value, so a same-cycle pop does not rescue the write.
    assign bad_wr = in_write & (~tag_ok | (|(sel & in_full)));

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | bad_wr;
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_hevc_ms_out_demux.sv
// Directed scoreboard bench for the two-stream, depth-16 demux.
module tb_hevc_ms_out_demux;
    import hevc_ms_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  in_din;
    logic        in_write;
    logic [1:0]  in_full;
    logic [15:0] out_dout;
    logic [1:0]  out_empty;
    logic [1:0]  out_read;
    logic        err;

    logic [7:0] sb0[$];
    logic [7:0] sb1[$];
    logic       exp_err;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    hevc_ms_out_demux #(.DEPTH(16), .FLUX(2), .DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_din    (in_din),
        .in_write  (in_write),
        .in_full   (in_full),
        .out_dout  (out_dout),
        .out_empty (out_empty),
        .out_read  (out_read),
        .err       (err)
    );

    task automatic chk(input string name, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic check_all(input string step);
        chk({step, ":in_full"},   {14'd0, in_full},
            {14'd0, (sb1.size() == 16), (sb0.size() == 16)});
        chk({step, ":out_empty"}, {14'd0, out_empty},
            {14'd0, (sb1.size() == 0), (sb0.size() == 0)});
        chk({step, ":err"}, {15'd0, err}, {15'd0, exp_err});
        if (sb0.size() > 0) chk({step, ":head0"}, {8'd0, out_dout[7:0]},  {8'd0, sb0[0]});
        if (sb1.size() > 0) chk({step, ":head1"}, {8'd0, out_dout[15:8]}, {8'd0, sb1[0]});
    endtask

    // One clock: drive, update the model from pre-edge state, then check after the edge.
    task automatic cyc(input logic wr, input logic t, input logic [7:0] d,
                       input logic [1:0] rd, input string step);
        ms_token_t tok;
        bit full0, full1;
        tok.tag  = t;
        tok.data = d;
        in_din   = tok;
        in_write = wr;
        out_read = rd;
        full0 = (sb0.size() == 16);
        full1 = (sb1.size() == 16);
        if (rd[0] && sb0.size() > 0) void'(sb0.pop_front());
        if (rd[1] && sb1.size() > 0) void'(sb1.pop_front());
        if (wr) begin
            if (t == 1'b0) begin
                if (full0) exp_err = 1'b1; else sb0.push_back(d);
            end else begin
                if (full1) exp_err = 1'b1; else sb1.push_back(d);
            end
        end
        @(posedge clk);
        #1;
        in_write = 1'b0;
        out_read = 2'b00;
        check_all(step);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_write = 1'b0;
        out_read = 2'b00;
        in_din   = '0;
        repeat (2) @(posedge clk);
        #1;
        sb0.delete();
        sb1.delete();
        exp_err = 1'b0;
        check_all("reset");
        chk("reset:dout", out_dout, 16'h0000);
        rst = 1'b0;
    endtask

    initial begin
        exp_err = 1'b0;

        // Reset state
        do_reset();

        // Routing by tag
        cyc(1'b1, 1'b1, 8'hA5, 2'b00, "route1");
        cyc(1'b1, 1'b0, 8'h3C, 2'b00, "route0");
        chk("route:empty", {14'd0, out_empty}, 16'h0000);
        chk("route:dout",  out_dout, 16'hA53C);
        cyc(1'b0, 1'b0, 8'h00, 2'b11, "route_drain");

        // Fill stream 0, overflow, stream 1 unaffected, drain in order
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(i), 2'b00, "fill");
        chk("fill:in_full", {14'd0, in_full}, 16'h0001);
        cyc(1'b1, 1'b0, 8'hFF, 2'b00, "overflow");
        chk("overflow:err", {15'd0, err}, 16'h0001);
        cyc(1'b1, 1'b1, 8'h42, 2'b00, "s1_while_s0_full");
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 8'h00, 2'b01, "drain0");
        chk("drain0:empty", {15'd0, out_empty[0]}, 16'h0001);
        cyc(1'b0, 1'b0, 8'h00, 2'b10, "drain1");

        // Concurrent write and read at full
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(i), 2'b00, "refill");
        cyc(1'b1, 1'b0, 8'hFF, 2'b01, "full_wr_rd");
        chk("full_wr_rd:head", {8'd0, out_dout[7:0]}, 16'h0001);
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 8'h00, 2'b01, "drain_nff");

        // Concurrent write and read at empty
        cyc(1'b1, 1'b1, 8'h77, 2'b10, "empty_wr_rd");
        chk("empty_wr_rd:head", {8'd0, out_dout[15:8]}, 16'h0077);
        cyc(1'b0, 1'b0, 8'h00, 2'b11, "empty_drain");

        // Reset mid-stream discards everything
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 8'(8'h20 + i), 2'b00, "mid0");
            cyc(1'b1, 1'b1, 8'(8'h30 + i), 2'b00, "mid1");
        end
        chk("mid:err_before", {15'd0, err}, 16'h0001);
        do_reset();
        cyc(1'b1, 1'b0, 8'h11, 2'b00, "post_reset");
        chk("post_reset:head", {8'd0, out_dout[7:0]}, 16'h0011);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
